// File: rtl/pulse_meas.sv
// pulse_meas: decodes the pulse generator's Sync/Pulse/Pre_Block pins and
// reports per-period timing as a valid/ready record.
module pulse_meas #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_in,
  input  logic             pulse_in,
  input  logic             preblk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] delay,
  output logic [CNT_W-1:0] width1,
  output logic [CNT_W-1:0] gap,
  output logic [CNT_W-1:0] width2,
  output logic [CNT_W-1:0] pb_width,
  output logic [7:0]       npulses,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun,
  output logic             sat
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_P1 = 3'd1,
    P1_HI   = 3'd2,
    GAP     = 3'd3,
    P2_HI   = 3'd4,
    TAIL    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Saturating increment; the top bit flags an increment lost to saturation.
  function automatic logic [CNT_W:0] inc_sat(input logic [CNT_W-1:0] v, input logic inc);
    logic [CNT_W:0] r;
    if (!inc) begin
      r = {1'b0, v};
    end else if (&v) begin
      r = {1'b1, v};
    end else begin
      r = {1'b0, v + {{(CNT_W-1){1'b0}}, 1'b1}};
    end
    return r;
  endfunction

  function automatic logic [8:0] inc_sat8(input logic [7:0] v, input logic inc);
    logic [8:0] r;
    if (!inc) begin
      r = {1'b0, v};
    end else if (&v) begin
      r = {1'b1, v};
    end else begin
      r = {1'b0, v + 8'd1};
    end
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_sh_r, pulse_sh_r, preblk_sh_r;
  logic                   sync_d_r, pulse_d_r;
  logic                   sync_lvl_s, pulse_lvl_s, preblk_lvl_s;
  logic                   sync_rise_s, pulse_rise_s, pulse_fall_s;

  state_t                 state_r, from_s, step_s, nstate_s;
  logic                   restart_s, publish_s, active_s;

  logic [CNT_W-1:0]       cnt_period_r, cnt_delay_r, cnt_w1_r, cnt_gap_r, cnt_w2_r, cnt_pb_r;
  logic [7:0]             cnt_np_r;
  logic                   cnt_sat_r;
  logic [CNT_W-1:0]       period_nx_s, delay_nx_s, w1_nx_s, gap_nx_s, w2_nx_s, pb_nx_s;
  logic [7:0]             np_nx_s;
  logic                   sat_nx_s;
  logic [6:0]             ovf_s;
  logic [CNT_W-1:0]       pub_delay_s, pub_gap_s;

  assign sync_lvl_s   = sync_sh_r[SYNC_STAGES-1];
  assign pulse_lvl_s  = pulse_sh_r[SYNC_STAGES-1];
  assign preblk_lvl_s = preblk_sh_r[SYNC_STAGES-1];
  assign sync_rise_s  = sync_lvl_s & ~sync_d_r;
  assign pulse_rise_s = pulse_lvl_s & ~pulse_d_r;
  assign pulse_fall_s = ~pulse_lvl_s & pulse_d_r;

  // Input synchronisers followed by the edge-detect history flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sh_r   <= {SYNC_STAGES{1'b0}};
      pulse_sh_r  <= {SYNC_STAGES{1'b0}};
      preblk_sh_r <= {SYNC_STAGES{1'b0}};
      sync_d_r    <= 1'b0;
      pulse_d_r   <= 1'b0;
    end else begin
      sync_sh_r   <= {sync_sh_r[SYNC_STAGES-2:0], sync_in};
      pulse_sh_r  <= {pulse_sh_r[SYNC_STAGES-2:0], pulse_in};
      preblk_sh_r <= {preblk_sh_r[SYNC_STAGES-2:0], preblk_in};
      sync_d_r    <= sync_lvl_s;
      pulse_d_r   <= pulse_lvl_s;
    end
  end

  // Next state: a Sync rise closes the period first, so a coincident Pulse
  // rise is evaluated from WAIT_P1 and becomes pulse 1 of the new period.
  always_comb begin
    restart_s = en & sync_rise_s;
    publish_s = restart_s & (state_r != IDLE);
    if (restart_s) begin
      from_s = WAIT_P1;
    end else begin
      from_s = state_r;
    end
    step_s = IDLE;
    case (from_s)
      WAIT_P1: step_s = pulse_rise_s ? P1_HI : WAIT_P1;
      P1_HI:   step_s = pulse_fall_s ? GAP   : P1_HI;
      GAP:     step_s = pulse_rise_s ? P2_HI : GAP;
      P2_HI:   step_s = pulse_fall_s ? TAIL  : P2_HI;
      TAIL:    step_s = TAIL;
      default: step_s = IDLE;
    endcase
    if (en) begin
      nstate_s = step_s;
    end else begin
      nstate_s = IDLE;
    end
  end

  // Each cycle is charged to the phase the FSM occupies after that cycle's edges.
  always_comb begin
    active_s = (nstate_s != IDLE);
    {ovf_s[0], period_nx_s} = inc_sat(restart_s ? CNT_ZERO : cnt_period_r, active_s);
    {ovf_s[1], delay_nx_s}  = inc_sat(restart_s ? CNT_ZERO : cnt_delay_r, nstate_s == WAIT_P1);
    {ovf_s[2], w1_nx_s}     = inc_sat(restart_s ? CNT_ZERO : cnt_w1_r, nstate_s == P1_HI);
    {ovf_s[3], gap_nx_s}    = inc_sat(restart_s ? CNT_ZERO : cnt_gap_r, nstate_s == GAP);
    {ovf_s[4], w2_nx_s}     = inc_sat(restart_s ? CNT_ZERO : cnt_w2_r, nstate_s == P2_HI);
    {ovf_s[5], pb_nx_s}     = inc_sat(restart_s ? CNT_ZERO : cnt_pb_r, active_s & preblk_lvl_s);
    {ovf_s[6], np_nx_s}     = inc_sat8(restart_s ? 8'd0 : cnt_np_r, active_s & pulse_rise_s);
    sat_nx_s = (restart_s ? 1'b0 : cnt_sat_r) | (|ovf_s);
    // Delay and gap are only meaningful once the closing pulse rise was seen.
    pub_delay_s = (state_r == WAIT_P1) ? CNT_ZERO : cnt_delay_r;
    pub_gap_s   = (state_r == GAP) ? CNT_ZERO : cnt_gap_r;
  end

  // FSM state and the running per-period counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_period_r <= CNT_ZERO;
      cnt_delay_r  <= CNT_ZERO;
      cnt_w1_r     <= CNT_ZERO;
      cnt_gap_r    <= CNT_ZERO;
      cnt_w2_r     <= CNT_ZERO;
      cnt_pb_r     <= CNT_ZERO;
      cnt_np_r     <= 8'd0;
      cnt_sat_r    <= 1'b0;
    end else begin
      state_r      <= nstate_s;
      cnt_period_r <= period_nx_s;
      cnt_delay_r  <= delay_nx_s;
      cnt_w1_r     <= w1_nx_s;
      cnt_gap_r    <= gap_nx_s;
      cnt_w2_r     <= w2_nx_s;
      cnt_pb_r     <= pb_nx_s;
      cnt_np_r     <= np_nx_s;
      cnt_sat_r    <= sat_nx_s;
    end
  end

  // Record register and handshake; a record that cannot be loaded is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= CNT_ZERO;
      delay     <= CNT_ZERO;
      width1    <= CNT_ZERO;
      gap       <= CNT_ZERO;
      width2    <= CNT_ZERO;
      pb_width  <= CNT_ZERO;
      npulses   <= 8'd0;
      sat       <= 1'b0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (publish_s && (!res_valid || res_ready)) begin
      period    <= cnt_period_r;
      delay     <= pub_delay_s;
      width1    <= cnt_w1_r;
      gap       <= pub_gap_s;
      width2    <= cnt_w2_r;
      pb_width  <= cnt_pb_r;
      npulses   <= cnt_np_r;
      sat       <= cnt_sat_r;
      res_valid <= 1'b1;
    end else if (publish_s) begin
      overrun   <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_meas.sv
// Self-checking bench for pulse_meas: randomized pulse trains scored against a
// per-period arithmetic model of the expected measurement record.
module tb_pulse_meas;

  typedef struct {
    longint p, n, s0, l0, s1, l1, s2, l2, pbs, pbl;
  } per_t;

  typedef struct {
    longint period, delay, width1, gap, width2, pb, np, sat;
  } rec_t;

  logic        clk, rst, en, sync_in, pulse_in, preblk_in, res_ready, rdy8;
  logic [31:0] period, delay, width1, gap, width2, pb_width;
  logic [7:0]  npulses;
  logic        res_valid, overrun, sat;
  logic [7:0]  period8, delay8, width18, gap8, width28, pb_width8, npulses8;
  logic        res_valid8, overrun8, sat8;

  int     total, bad, scen;
  longint cyc, hold;
  rec_t   got[$], got8[$], expq[$], exp8[$];
  per_t   plq[$];
  rec_t   held;

  pulse_meas #(.CNT_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_in(sync_in), .pulse_in(pulse_in),
    .preblk_in(preblk_in), .period(period), .delay(delay), .width1(width1),
    .gap(gap), .width2(width2), .pb_width(pb_width), .npulses(npulses),
    .res_valid(res_valid), .res_ready(res_ready), .overrun(overrun), .sat(sat)
  );

  pulse_meas #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .en(en), .sync_in(sync_in), .pulse_in(pulse_in),
    .preblk_in(preblk_in), .period(period8), .delay(delay8), .width1(width18),
    .gap(gap8), .width2(width28), .pb_width(pb_width8), .npulses(npulses8),
    .res_valid(res_valid8), .res_ready(rdy8), .overrun(overrun8), .sat(sat8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t cap_main();
    rec_t r;
    r.period = longint'(period);   r.delay  = longint'(delay);
    r.width1 = longint'(width1);   r.gap    = longint'(gap);
    r.width2 = longint'(width2);   r.pb     = longint'(pb_width);
    r.np     = longint'(npulses);  r.sat    = longint'(sat);
    return r;
  endfunction

  function automatic rec_t cap8();
    rec_t r;
    r.period = longint'(period8);  r.delay  = longint'(delay8);
    r.width1 = longint'(width18);  r.gap    = longint'(gap8);
    r.width2 = longint'(width28);  r.pb     = longint'(pb_width8);
    r.np     = longint'(npulses8); r.sat    = longint'(sat8);
    return r;
  endfunction

  // Records are captured when a transfer is about to happen at the next edge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) got.push_back(cap_main());
    if (!rst && res_valid8 && rdy8) got8.push_back(cap8());
  end

  // Expected record for one period, derived from the waveform description alone.
  function automatic rec_t model(input per_t q, input int w);
    rec_t   r;
    longint mx;
    mx       = (longint'(1) << w) - 1;
    r.period = (q.p > mx) ? mx : q.p;
    r.sat    = (q.p > mx) ? 1 : 0;
    r.delay  = (q.n >= 1) ? q.s0 : 0;
    r.width1 = (q.n >= 1) ? q.l0 : 0;
    r.gap    = (q.n >= 2) ? q.s1 - (q.s0 + q.l0) : 0;
    r.width2 = (q.n >= 2) ? q.l1 : 0;
    r.pb     = q.pbl;
    r.np     = q.n;
    return r;
  endfunction

  function automatic longint ru(input int unsigned lo, input int unsigned hi);
    return longint'($urandom_range(hi, lo));
  endfunction

  function automatic per_t mk_per(input longint p, input longint n, input longint s0,
                                  input longint l0, input longint s1, input longint l1,
                                  input longint pbs, input longint pbl);
    per_t q;
    q.p = p; q.n = n; q.s0 = s0; q.l0 = l0; q.s1 = s1; q.l1 = l1;
    q.s2 = 0; q.l2 = 0; q.pbs = pbs; q.pbl = pbl;
    return q;
  endfunction

  function automatic per_t rand_per(input longint n, input longint plen);
    per_t q;
    q.p  = plen; q.n = n;
    q.s0 = ru(5, 45); q.l0 = ru(1, 30);
    q.s1 = q.s0 + q.l0 + ru(1, 40); q.l1 = ru(1, 30);
    q.s2 = q.s1 + q.l1 + ru(1, 40); q.l2 = ru(1, 30);
    q.pbs = ru(3, 60); q.pbl = ru(1, 200);
    return q;
  endfunction

  function automatic logic in_pulse(input per_t q, input longint o);
    logic v;
    v = 1'b0;
    if (q.n >= 1 && o >= q.s0 && o < q.s0 + q.l0) v = 1'b1;
    if (q.n >= 2 && o >= q.s1 && o < q.s1 + q.l1) v = 1'b1;
    if (q.n >= 3 && o >= q.s2 && o < q.s2 + q.l2) v = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cmp_rec(input rec_t o, input rec_t e, input string t);
    check({t, "_period"}, o.period, e.period);
    check({t, "_delay"},  o.delay,  e.delay);
    check({t, "_width1"}, o.width1, e.width1);
    check({t, "_gap"},    o.gap,    e.gap);
    check({t, "_width2"}, o.width2, e.width2);
    check({t, "_pbw"},    o.pb,     e.pb);
    check({t, "_np"},     o.np,     e.np);
    check({t, "_sat"},    o.sat,    e.sat);
  endtask

  task automatic probe();
    if (scen == 3 && (cyc == 1500 || cyc == 2400)) begin
      check("stall_valid", longint'(res_valid), 1);
      check("stall_ovr", longint'(overrun), (cyc == 2400) ? 1 : 0);
      cmp_rec(cap_main(), held, "stall_hold");
    end
  endtask

  task automatic drive_period(input per_t q, input longint rst_off);
    for (longint o = 0; o < q.p; o++) begin
      rst       = 1'b0;
      sync_in   = (o < 3);
      pulse_in  = in_pulse(q, o);
      preblk_in = (o >= q.pbs) && (o < q.pbs + q.pbl);
      res_ready = (cyc >= hold);
      @(posedge clk); #1;
      cyc++;
      probe();
      if (o == rst_off) begin
        rst = 1'b1;
        #1;
        check("rst_valid",  longint'(res_valid), 0);
        check("rst_period", longint'(period), 0);
        check("rst_width1", longint'(width1), 0);
        check("rst_np",     longint'(npulses), 0);
        check("rst_ovr",    longint'(overrun), 0);
      end
    end
  endtask

  task automatic run_list(input longint rst_k, input longint rst_off);
    foreach (plq[k]) drive_period(plq[k], (k == rst_k) ? rst_off : -1);
    drive_period(mk_per(30, 0, 0, 0, 0, 0, 0, 0), -1);
  endtask

  task automatic start_scen(input int id, input longint h);
    scen = id; hold = h;
    rst = 1'b1; en = 1'b1; sync_in = 1'b0; pulse_in = 1'b0; preblk_in = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got.delete(); got8.delete(); expq.delete(); exp8.delete(); plq.delete();
    rst = 1'b0; cyc = 0;
  endtask

  task automatic end_scen();
    check($sformatf("s%0d_count", scen), longint'(got.size()), longint'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      cmp_rec(got[i], expq[i], $sformatf("s%0d_r%0d", scen, i));
  endtask

  initial begin
    total = 0; bad = 0; rdy8 = 1'b1; cyc = 0; hold = 0;

    // Reference waveform from the test plan.
    start_scen(1, 0);
    check("reset_valid",  longint'(res_valid), 0);
    check("reset_period", longint'(period), 0);
    check("reset_ovr",    longint'(overrun), 0);
    check("reset_sat",    longint'(sat), 0);
    for (int k = 0; k < 3; k++) plq.push_back(mk_per(1000, 2, 10, 20, 60, 10, 5, 75));
    foreach (plq[k]) expq.push_back(model(plq[k], 32));
    run_list(-1, 0);
    end_scen();

    // Random pulse counts and period lengths.
    start_scen(2, 0);
    for (int k = 0; k < 6; k++) plq.push_back(rand_per(ru(1, 3), ru(300, 1500)));
    foreach (plq[k]) expq.push_back(model(plq[k], 32));
    run_list(-1, 0);
    end_scen();

    // Consumer stalled for 2500 cycles: first record held, later ones dropped.
    start_scen(3, 2500);
    for (int k = 0; k < 5; k++) plq.push_back(rand_per(2, 1000));
    begin
      longint cum;
      bit     taken;
      cum = 0; taken = 1'b0;
      foreach (plq[k]) begin
        cum += plq[k].p;
        if (cum >= hold) expq.push_back(model(plq[k], 32));
        else if (!taken) begin
          expq.push_back(model(plq[k], 32));
          taken = 1'b1;
        end
      end
    end
    held = model(plq[0], 32);
    run_list(-1, 0);
    check("stall_ovr_sticky", longint'(overrun), 1);
    end_scen();

    // Single pulse per period.
    start_scen(4, 0);
    for (int k = 0; k < 3; k++) plq.push_back(mk_per(1000, 1, 10, 20, 0, 0, 5, 75));
    foreach (plq[k]) expq.push_back(model(plq[k], 32));
    run_list(-1, 0);
    end_scen();

    // Three pulses per period.
    start_scen(5, 0);
    for (int k = 0; k < 4; k++) plq.push_back(rand_per(3, ru(300, 1200)));
    foreach (plq[k]) expq.push_back(model(plq[k], 32));
    run_list(-1, 0);
    end_scen();

    // Pulse rise coincident with Sync rise after the first period.
    start_scen(6, 0);
    plq.push_back(rand_per(2, ru(300, 800)));
    for (int k = 0; k < 4; k++) begin
      per_t q;
      q = rand_per(2, ru(300, 800));
      q.s1 = q.s1 - q.s0;
      q.s0 = 0;
      plq.push_back(q);
    end
    foreach (plq[k]) expq.push_back(model(plq[k], 32));
    run_list(-1, 0);
    end_scen();

    // Period longer than an 8-bit counter can hold.
    start_scen(7, 0);
    for (int k = 0; k < 3; k++) plq.push_back(mk_per(300, 2, 10, 20, 60, 10, 5, 75));
    foreach (plq[k]) begin
      expq.push_back(model(plq[k], 32));
      exp8.push_back(model(plq[k], 8));
    end
    run_list(-1, 0);
    end_scen();
    check("sat8_count", longint'(got8.size()), longint'(exp8.size()));
    for (int i = 0; i < got8.size() && i < exp8.size(); i++)
      cmp_rec(got8[i], exp8[i], $sformatf("sat8_r%0d", i));

    // Reset during pulse 1: that period is lost, measurement restarts at the next Sync.
    start_scen(8, 0);
    for (int k = 0; k < 5; k++) begin
      per_t q;
      q = rand_per(2, ru(300, 900));
      if (k == 2) begin
        q.s0 = 10; q.l0 = 20; q.s1 = 60;
      end
      plq.push_back(q);
    end
    foreach (plq[k]) if (k != 2) expq.push_back(model(plq[k], 32));
    run_list(2, 20);
    end_scen();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_meas.md
Name: pulse_meas

Overview:
- Receive-side checker for the pulse generator's output pins. Observes Sync, Pulse and Pre_Block on one clock and measures the timing of each pulse-sequence period.
- Timing measured: period, delay, pulse-1 width, gap, pulse-2 width, Pre_Block width and pulse count.
- Each measurement set is delivered through a valid/ready record interface. Used in loopback self-test and in simulation benches as the decoder for what the generator emits.

Parameters:
- CNT_W, 32, width of every timing counter in clk cycles.
- SYNC_STAGES, 2, synchroniser flops on each observed input (min 2).

Ports:
- clk  in  1  measurement clock (same 100 MHz domain as clk_pll).
- rst  in  1  asynchronous, active-high reset.
- en  in  1  measurement enable; low forces IDLE at next clk.
- sync_in  in  1  observed Sync.
- pulse_in  in  1  observed Pulse.
- preblk_in  in  1  observed Pre_Block.
- period  out  CNT_W  Sync rise to next Sync rise.
- delay  out  CNT_W  Sync rise to first Pulse rise.
- width1  out  CNT_W  first Pulse high time.
- gap  out  CNT_W  first Pulse fall to second Pulse rise.
- width2  out  CNT_W  second Pulse high time.
- pb_width  out  CNT_W  total Pre_Block high cycles within period.
- npulses  out  8  Pulse rising edges within period (saturating).
- res_valid  out  1  record available.
- res_ready  in  1  consumer accepts record.
- overrun  out  1  sticky: a record was dropped.
- sat  out  1  in current record, some counter saturated.

Behaviour:
- Reset: all outputs 0. FSM state IDLE. Reset is asynchronous, mid-operation included; the partial period is discarded.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop. Input-to-internal-edge latency is SYNC_STAGES+1 cycles. All counts are relative, so this latency cancels.
- Counters:
  - Increment by 1 per clk and saturate at all-ones; saturation sets the record's sat bit.
  - npulses saturates at 255.
- FSM states:
  - IDLE: wait for en=1 and Sync rising edge. Go to WAIT_P1 and clear all counters. No record is produced for the first Sync.
  - WAIT_P1: delay counts. Pulse rise goes to P1_HI.
  - P1_HI: width1 counts. Pulse fall goes to GAP.
  - GAP: gap counts. Pulse rise goes to P2_HI.
  - P2_HI: width2 counts. Pulse fall goes to TAIL.
  - TAIL: additional Pulse rises only increment npulses.
- Period-wide counting:
  - In all non-IDLE states, period counts every cycle.
  - pb_width counts every cycle the synchronised Pre_Block is high.
  - npulses increments on every Pulse rise.
- Sync rising edge in any non-IDLE state:
  - Publish the record with period = count+1. Unreached measurements are published as 0; a pulse still high publishes its width so far.
  - Clear counters, restart counting in the same cycle, and go to WAIT_P1.
- Simultaneous Sync rise and Pulse rise: the period closes first. The pulse is counted as the first pulse of the new period (delay=0, enter P1_HI).
- Publish/handshake:
  - Output registers load and res_valid=1 one cycle after the Sync edge.
  - A transfer occurs when res_valid and res_ready are both high; res_valid drops the next cycle unless a new publish occurs in that same cycle.
  - Outputs are stable while res_valid=1 and not accepted.
  - Publish while res_valid=1 and res_ready=0: the new record is dropped, overrun is set, and the old record is held.
  - Publish in the same cycle as acceptance: the new record loads and res_valid stays 1.
- overrun clears only on rst.
- en low: go to IDLE and discard the partial period. A pending res_valid record is kept until accepted.
- period counter saturated with no Sync edge: remain in the current state. The record is published at the next Sync with sat=1.

Test Plan:
- Sync period 1000 cycles, Pulse high at offsets 10–29 and 60–69, Pre_Block high 5–79, res_ready=1.
  - Required from second Sync on: period=1000, delay=10, width1=20, gap=30, width2=10, pb_width=75, npulses=2, sat=0.
- Same stimulus with res_ready held 0 for 2500 cycles.
  - First record held unchanged, overrun=1 after the second publish.
  - After res_ready=1: one transfer, then the next record arrives normally.
- Single pulse per period (only 10–29): gap=0, width2=0, npulses=1.
- Three pulses per period: gap and width2 describe pulse 2; npulses=3.
- Sync rise coincident with Pulse rise at offset 0.
  - Required: delay=0 in the following record; the preceding record's npulses excludes that pulse.
- CNT_W=8, Sync period 300: period=255, sat=1.
- rst asserted mid-P1_HI: all outputs 0 immediately. The next record appears only after two further Sync edges.
